// File: rtl/fir_wb_arbiter.sv
// Round-robin, cycle-locked Wishbone arbiter sharing the FIR slave port among NR_MASTERS masters.
// Optional bus-hang watchdog enabled by defining FIR_ARB_WATCHDOG_EN.
module fir_wb_arbiter #(
  parameter int NR_MASTERS = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst_sys_n,
  input  logic [32*NR_MASTERS-1:0] m_adr_i,
  input  logic [32*NR_MASTERS-1:0] m_dat_i,
  input  logic [4*NR_MASTERS-1:0]  m_sel_i,
  input  logic [NR_MASTERS-1:0]    m_we_i,
  input  logic [NR_MASTERS-1:0]    m_cyc_i,
  input  logic [NR_MASTERS-1:0]    m_stb_i,
  output logic [31:0]              m_dat_o,
  output logic [NR_MASTERS-1:0]    m_ack_o,
  output logic [NR_MASTERS-1:0]    m_err_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  input  logic [31:0]              s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NR_MASTERS-1:0]    grant_o
);
  localparam int GW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

`ifdef FIR_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t                    state_q, state_d;
  logic [NR_MASTERS-1:0]     grant_d;
  logic [GW-1:0]             gidx_q, gidx_d, last_q, last_d, cand;
  logic                      found;

  logic [NR_MASTERS-1:0][31:0] adr_a, dat_a;
  logic [NR_MASTERS-1:0][3:0]  sel_a;

  for (genvar k = 0; k < NR_MASTERS; k++) begin : g_unpack
    assign adr_a[k] = m_adr_i[32*k +: 32];
    assign dat_a[k] = m_dat_i[32*k +: 32];
    assign sel_a[k] = m_sel_i[4*k +: 4];
  end

  assign m_dat_o = s_dat_i;

`ifdef FIR_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] wd_q;
  logic          wd_hit;

  // Fires on the cycle the count saturates while the beat is still unanswered.
  assign wd_hit = (state_q == BUSY) && m_cyc_i[gidx_q] && m_stb_i[gidx_q] &&
                  !s_ack_i && !s_err_i && (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n)
      wd_q <= '0;
    else if (state_q == BUSY && s_stb_o && !s_ack_i && !s_err_i)
      wd_q <= wd_q + 1'b1;
    else
      wd_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT >= 2);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cand    = '0;
    found   = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      IDLE: begin
        // Search upward from the master after the last one served.
        for (int i = 1; i <= NR_MASTERS; i++) begin
          cand = GW'((int'(last_q) + i) % NR_MASTERS);
          if (!found && m_cyc_i[cand]) begin
            found  = 1'b1;
            gidx_d = cand;
          end
        end
        if (found) begin
          grant_d         = '0;
          grant_d[gidx_d] = 1'b1;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        s_adr_o = adr_a[gidx_q];
        s_dat_o = dat_a[gidx_q];
        s_sel_o = sel_a[gidx_q];
        s_we_o  = m_we_i[gidx_q];
        s_cyc_o = m_cyc_i[gidx_q];
        s_stb_o = m_stb_i[gidx_q];
        m_ack_o[gidx_q] = s_ack_i & s_stb_o;
        m_err_o[gidx_q] = s_err_i & s_stb_o;
`ifdef FIR_ARB_WATCHDOG_EN
        if (wd_hit) begin
          s_cyc_o         = 1'b0;
          s_stb_o         = 1'b0;
          m_ack_o         = '0;
          m_err_o[gidx_q] = 1'b1;
          state_d         = TERM;
        end else
`endif
        if (!m_cyc_i[gidx_q]) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end
`ifdef FIR_ARB_WATCHDOG_EN
      TERM: begin
        if (!m_cyc_i[gidx_q]) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      grant_o <= '0;
      gidx_q  <= '0;
      last_q  <= GW'(NR_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: doc/fir_wb_arbiter.md
Name: fir_wb_arbiter

Overview:
- Shares the tile's FIR accelerator Wishbone slave port between NR_MASTERS Wishbone masters, for example the network adapter master and a local DMA/config master.
- Round-robin, cycle-locked arbitration: a grant is held for the whole Wishbone cycle (cyc high).
- Muxes the granted master's signals onto the single slave port and routes ack/err back to the granted master only.
- Optional bus-hang watchdog terminates stuck cycles with err.

Parameters:
- NR_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT, 256, watchdog limit in cycles of stb high without ack/err (≥2). Used only with the watchdog macro.

Ports:
- clk  in  1  system clock.
- rst_sys_n  in  1  reset, asynchronous, active-low.
- m_adr_i  in  32*NR_MASTERS  per-master address; master k occupies [32k+31:32k].
- m_dat_i  in  32*NR_MASTERS  per-master write data.
- m_sel_i  in  4*NR_MASTERS  per-master byte selects.
- m_we_i  in  NR_MASTERS  per-master write enable.
- m_cyc_i  in  NR_MASTERS  per-master cycle request.
- m_stb_i  in  NR_MASTERS  per-master strobe.
- m_dat_o  out  32  read data, broadcast to all masters (s_dat_i passthrough).
- m_ack_o  out  NR_MASTERS  ack, granted master only.
- m_err_o  out  NR_MASTERS  err, granted master only.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- grant_o  out  NR_MASTERS  one-hot registered grant, status only.

Behaviour:
- Reset: asynchronous on rst_sys_n low.
  - state=IDLE, grant_o=0, last_grant=NR_MASTERS-1, so master 0 wins first.
  - All s_* outputs and m_ack_o/m_err_o are 0; m_dat_o follows s_dat_i.
  - Reset mid-transfer abandons the cycle: s_cyc_o drops immediately, and no ack/err is delivered.
- State machine:
  - IDLE:
    - s_cyc_o=s_stb_o=0.
    - If any m_cyc_i is high, grant the first requester searching (last_grant+1) mod N upward.
    - Registered: grant_o and BUSY take effect next edge.
    - Latency from m_cyc_i to s_cyc_o is therefore 1 cycle.
  - BUSY:
    - s_adr/dat/sel/we/cyc/stb are combinationally the granted master's inputs.
    - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; all other masters see 0.
    - Stay in BUSY while m_cyc_i[g]=1, across any number of back-to-back stb beats.
    - When m_cyc_i[g]=0: go to IDLE, set last_grant=g, clear grant_o. This leaves one dead cycle between different masters' cycles.
    - ack/err arriving while s_stb_o=0 is discarded and not forwarded.
  - TERM (watchdog only):
    - s_cyc_o=s_stb_o=0, no ack/err.
    - Wait for m_cyc_i[g]=0, then go to IDLE with last_grant=g.
- Simultaneous events:
  - Ack and m_cyc_i[g] falling in the same cycle: the ack is forwarded and the state still returns to IDLE.
  - Requests appearing while BUSY wait; there is no preemption.
  - A master deasserting cyc before being granted is simply not granted.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,N-1,0.

Optional Feature:
- Macro: FIR_ARB_WATCHDOG_EN.
- Defined:
  - A $clog2(TIMEOUT)-bit counter increments in BUSY while s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ack, err, or leaving BUSY.
  - When the count reaches TIMEOUT-1 with still no response, m_err_o[g]=1 for exactly that one cycle, s_cyc_o/s_stb_o are forced 0 that cycle, and the next state is TERM.
- Undefined: no counter and no TERM state; a hung slave holds the grant indefinitely.

Test Plan:
- Reset then m_cyc_i=2'b11 with stb, slave acks each beat after 1 cycle:
  - grant_o=01 on the first edge; s_cyc_o high 1 cycle after request.
  - After master 0 drops cyc: 1 idle cycle, then grant_o=10.
- Master 1 alone performs a 4-beat burst, ack every cycle:
  - 4 acks on m_ack_o[1], none on m_ack_o[0].
  - s_adr_o tracks m_adr_i[63:32] each beat; grant held throughout.
- Master 0 reads while s_dat_i=32'hDEADBEEF with ack:
  - m_ack_o=01 for 1 cycle; m_dat_o=32'hDEADBEEF.
- Slave returns s_err_i instead of ack:
  - m_err_o[g]=1 for 1 cycle, m_ack_o=0; arbiter stays BUSY until cyc drops.
- rst_sys_n pulsed low mid-burst:
  - s_cyc_o, grant_o and m_ack_o go 0 asynchronously.
  - After release with both masters requesting, master 0 is granted.
- FIR_ARB_WATCHDOG_EN defined, TIMEOUT=16, slave never acks:
  - m_err_o[g]=1 exactly 16 cycles after stb rises, then s_cyc_o=0 (TERM).
  - Returns to IDLE one cycle after the master drops cyc.
